// File: rtl/motion_scheduler.sv
// motion_scheduler: round-robin move scheduler for six stepper motors.
// Each motor has a one-entry target slot. When every motor is calibrated
// and the pulse generator is idle, one pending target is issued to the
// control datapath. The scheduler then tracks Busy to detect the end of
// the move, or a missing or stuck move.
//
// Ports
//   sysclk      : clock, rising edge
//   INIT_n      : asynchronous active-low reset, release synchronized
//   initFlag    : per-motor origin-calibrated flags (all must be set to grant)
//   cmd_valid   : per-motor target request
//   cmd_value   : motor k target at [10k+9:10k]
//   cmd_ready   : per-motor slot empty
//   Busy        : pulse generator active
//   i_Motor     : granted motor index (0..5)
//   Value       : granted target coordinate
//   issue       : one-cycle strobe for a new i_Motor/Value
//   done        : one-cycle per-motor move-complete pulse
//   timeout_err : sticky stuck-Busy flag, cleared only by reset
//   idle        : IDLE state with every slot empty
module motion_scheduler #(
    parameter int unsigned START_TO = 8,
    parameter int unsigned RUN_TO   = 1048575
) (
    input  logic        sysclk,
    input  logic        INIT_n,
    input  logic [5:0]  initFlag,
    input  logic [5:0]  cmd_valid,
    input  logic [59:0] cmd_value,
    output logic [5:0]  cmd_ready,
    input  logic        Busy,
    output logic [3:0]  i_Motor,
    output logic [9:0]  Value,
    output logic        issue,
    output logic [5:0]  done,
    output logic        timeout_err,
    output logic        idle
);

    localparam int unsigned N_MOT     = 6;
    localparam int unsigned VAL_W     = 10;
    localparam int unsigned CNT_W     = 20;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned ISSUE_CYC = 3;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ISSUE_LIM = CNT_W'(ISSUE_CYC - 1);
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_END   = 2'd3
    } state_t;

    // Reset: asserts asynchronously, releases after two sysclk edges
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge sysclk or negedge INIT_n) begin
        if (!INIT_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [N_MOT-1:0]              r_slot_full;
    logic [N_MOT-1:0][VAL_W-1:0]   r_slot_val;
    logic [SEL_W-1:0]              r_rr_ptr;
    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_cnt_nxt;
    logic [CNT_W-1:0]              w_cnt_inc;
    logic [SEL_W-1:0]              r_motor;
    logic [VAL_W-1:0]              r_value;
    logic                          r_issue;
    logic [N_MOT-1:0]              r_done;
    logic                          r_timeout;

    logic                          w_any;
    logic [SEL_W-1:0]              w_grant_idx;
    logic [SEL_W-1:0]              w_rr_idx;
    logic                          w_grant;
    logic                          w_done;
    logic                          w_to;

    // Round-robin pick: first full slot at or after the pointer
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_rr_idx    = '0;
        for (int i = 0; i < int'(N_MOT); i++) begin
            w_rr_idx = SEL_W'((int'(r_rr_ptr) + i) % int'(N_MOT));
            if (!w_any && r_slot_full[w_rr_idx]) begin
                w_any       = 1'b1;
                w_grant_idx = w_rr_idx;
            end
        end
    end

    // Saturating increment so long moves never wrap the counter
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_to        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((&initFlag) && !Busy && w_any) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // hold i_Motor/Value while the control datapath latches them
                if (r_cnt >= ISSUE_LIM) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_START;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_START: begin
                if (Busy) begin
                    // this edge already saw Busy high once
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_WAIT_END;
                end else if (r_cnt >= START_LIM) begin
                    // no motion generated: zero-displacement move
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_END: begin
                if (!Busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt >= RUN_LIM) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: slots, grant registers, counter and status outputs
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_slot_full <= '0;
            r_slot_val  <= '0;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_motor     <= '0;
            r_value     <= '0;
            r_issue     <= 1'b0;
            r_done      <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_issue <= w_grant;
            r_done  <= '0;
            if (w_done) begin
                r_done[r_motor] <= 1'b1;
            end
            if (w_to) begin
                r_timeout <= 1'b1;
            end
            if (w_grant) begin
                r_motor  <= w_grant_idx;
                r_value  <= r_slot_val[w_grant_idx];
                r_rr_ptr <= (w_grant_idx == SEL_W'(N_MOT - 1)) ? '0
                                                               : w_grant_idx + SEL_W'(1);
            end
            // a granted slot is full, so grant-clear and load never collide
            for (int k = 0; k < int'(N_MOT); k++) begin
                if (w_grant && (w_grant_idx == SEL_W'(k))) begin
                    r_slot_full[k] <= 1'b0;
                end else if (cmd_valid[k] && !r_slot_full[k]) begin
                    r_slot_full[k] <= 1'b1;
                    r_slot_val[k]  <= cmd_value[k*VAL_W +: VAL_W];
                end
            end
        end
    end

    assign cmd_ready   = ~r_slot_full;
    assign i_Motor     = {1'b0, r_motor};
    assign Value       = r_value;
    assign issue       = r_issue;
    assign done        = r_done;
    assign timeout_err = r_timeout;
    assign idle        = (r_state == S_IDLE) && (r_slot_full == '0);

endmodule

// File: doc/motion_scheduler.md
MOTION_SCHEDULER -- requirements
Module: motion_scheduler

Interface
REQ-001 SHALL have parameter START_TO, default 8, the cycles allowed after issue for Busy to rise.
REQ-002 SHALL have parameter RUN_TO, default 1048575, the maximum cycles Busy may stay high per move.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port INIT_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port initFlag, input, 6 bits: per-motor origin-calibrated flags.
REQ-006 SHALL have port cmd_valid, input, 6 bits: per-motor target request.
REQ-007 SHALL have port cmd_value, input, 60 bits: motor k target at bits [10k+9:10k].
REQ-008 SHALL have port cmd_ready, output, 6 bits: motor k slot empty.
REQ-009 SHALL have port Busy, input, 1 bit: pulse generator active.
REQ-010 SHALL have port i_Motor, output, 4 bits: motor index 0..5 driven to the control datapath.
REQ-011 SHALL have port Value, output, 10 bits: target coordinate driven to the control datapath.
REQ-012 SHALL have port issue, output, 1 bit: one-cycle strobe marking a new i_Motor/Value.
REQ-013 SHALL have port done, output, 6 bits: one-cycle per-motor move-complete pulse.
REQ-014 SHALL have port timeout_err, output, 1 bit: sticky error flag.
REQ-015 SHALL have port idle, output, 1 bit: high when in IDLE with no pending slot.

Function
REQ-016 SHALL hold one pending slot per motor; slot k loads cmd_value[k] when cmd_valid[k] & cmd_ready[k], and cmd_ready[k] equals slot-empty.
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT_START and WAIT_END.
REQ-018 SHALL arbitrate in IDLE only when &initFlag==1 and Busy==0, granting round-robin starting at the index after the last grant (index 0 after reset).
REQ-019 SHALL, on grant, register i_Motor and Value, clear the granted slot so that cmd_ready rises the next cycle, assert issue for exactly one cycle, and enter ISSUE.
REQ-020 SHALL, in ISSUE, hold i_Motor/Value stable for 3 cycles (control datapath latency) and then enter WAIT_START with a cleared counter.
REQ-021 SHALL, in WAIT_START, enter WAIT_END when Busy==1; if Busy is still low after START_TO cycles (zero-displacement move), SHALL pulse done[i_Motor] and return to IDLE.
REQ-022 SHALL, in WAIT_END, on Busy falling, pulse done[i_Motor] for one cycle and return to IDLE.
REQ-023 SHALL, in WAIT_END, if Busy stays high for RUN_TO cycles, set timeout_err, skip the done pulse and return to IDLE.
REQ-024 SHALL hold i_Motor/Value between moves at their last values.
REQ-025 SHALL let a request for motor k be accepted while motor k's previous move is in flight, since its slot is already empty.
REQ-026 SHALL, when &initFlag drops to 0 in IDLE, grant nothing and retain pending slots.
REQ-027 SHALL, when &initFlag drops to 0 mid-move, complete the current move normally.
REQ-028 SHALL use counters 20 bits wide that saturate and never wrap.
REQ-029 SHALL clear timeout_err only by reset.
REQ-030 SHALL drive idle = (state==IDLE) & all slots empty.

Reset
REQ-031 SHALL, on INIT_n low (asynchronous), enter IDLE, empty all slots (cmd_ready=6'h3F), and drive i_Motor=0, Value=0, issue=0, done=0, timeout_err=0, idle=1, and round-robin pointer=0.
REQ-032 SHALL, on INIT_n assertion mid-move, discard the in-flight move with no done pulse.
REQ-033 SHALL synchronize the release of INIT_n with two flops.

Verification
REQ-034 SHALL cover: initFlag=6'h3F, cmd_valid=6'h01, value=300, Busy high 50 cycles -> issue once, i_Motor=0, Value=300, done=6'h01 one cycle after Busy falls.
REQ-035 SHALL cover: cmd_valid=6'h29 (motors 0,3,5) in the same cycle -> grants in order 0,3,5; after those, requests on 5 then 0 -> 0 granted before 5.
REQ-036 SHALL cover: initFlag=6'h1F with request pending -> no issue; then initFlag=6'h3F -> issue within 1 cycle.
REQ-037 SHALL cover: Busy never rises -> done pulses 3+START_TO cycles after issue, and timeout_err=0.
REQ-038 SHALL cover: RUN_TO=100 and Busy stuck high -> timeout_err=1 at cycle 100, no done, FSM back in IDLE, next grant proceeds.
REQ-039 SHALL cover: INIT_n low during WAIT_END -> all outputs at their reset values immediately, cmd_ready=6'h3F.
